// File: rtl/pc_sequencer.sv
// pc_sequencer: sequences PC load strobes for step commands and fetches/loads reset, IRQ/BRK and NMI vectors.
// Build option: define PC_SEQ_NMI_EN to include NMI edge detection and the FFFA vector.
module pc_sequencer #(
    parameter int unsigned STROBE_LEN  = 2,
    parameter logic [7:0]  VEC_HI_BYTE = 8'hFF
) (
    input  logic        sys_clock,
    input  logic        reset,
    input  logic        phase_2_rising,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic        nmi_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    output logic        pcl_pcl,
    output logic        adl_pcl,
    output logic        pch_pch,
    output logic        adh_pch,
    output logic        increment_pc,
    output logic        adl_drive,
    output logic        adh_drive,
    output logic [7:0]  adl_out,
    output logic [7:0]  adh_out,
    output logic        busy,
    output logic        vec_done
);
    localparam int unsigned CNT_W      = 3;
    localparam logic [1:0]  OP_INC     = 2'd1;
    localparam logic [1:0]  OP_LOAD_AB = 2'd2;
    localparam logic [1:0]  OP_BRK     = 2'd3;
    localparam logic [7:0]  VEC_NMI_LO = 8'hFA;
    localparam logic [7:0]  VEC_RST_LO = 8'hFC;
    localparam logic [7:0]  VEC_IRQ_LO = 8'hFE;

    typedef enum logic [2:0] {
        RST_VEC, IDLE, STEP, VLO_REQ, VLO_WAIT, VHI_REQ, VHI_WAIT, VLOAD
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               open_q, open_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         vec_lo_q, vec_lo_d;
    logic [7:0]         lo_q, lo_d, hi_q, hi_d;
    logic               irq_q, irq_d;
    logic               nmi_clr;
    logic               strb_on;

    logic        cmd_ready_q, cmd_ready_d, mem_req_q, mem_req_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        pcl_pcl_q, pcl_pcl_d, adl_pcl_q, adl_pcl_d;
    logic        pch_pch_q, pch_pch_d, adh_pch_q, adh_pch_d;
    logic        increment_pc_q, increment_pc_d;
    logic        adl_drive_q, adl_drive_d, adh_drive_q, adh_drive_d;
    logic [7:0]  adl_out_q, adl_out_d, adh_out_q, adh_out_d;
    logic        busy_q, busy_d, vec_done_q, vec_done_d;

    assign irq_d = ~irq_n & ~i_flag;

`ifdef PC_SEQ_NMI_EN
    logic nmi_prev_q, nmi_pend_q, nmi_pend_d;

    // A fresh edge re-arms the flag even in the cycle the pending one is consumed.
    assign nmi_pend_d = (nmi_pend_q & ~nmi_clr) | (nmi_prev_q & ~nmi_n);

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            nmi_prev_q <= 1'b1;
            nmi_pend_q <= 1'b0;
        end else begin
            nmi_prev_q <= nmi_n;
            nmi_pend_q <= nmi_pend_d;
        end
    end
`else
    logic nmi_pend_q, nmi_pend_d, unused_nmi;

    assign nmi_pend_q = 1'b0;
    assign nmi_pend_d = 1'b0;
    assign unused_nmi = nmi_n ^ nmi_clr;
`endif

    // State and registered outputs.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q        <= RST_VEC;
            op_q           <= '0;
            open_q         <= 1'b0;
            cnt_q          <= '0;
            vec_lo_q       <= '0;
            lo_q           <= '0;
            hi_q           <= '0;
            irq_q          <= 1'b0;
            cmd_ready_q    <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            pcl_pcl_q      <= 1'b0;
            adl_pcl_q      <= 1'b0;
            pch_pch_q      <= 1'b0;
            adh_pch_q      <= 1'b0;
            increment_pc_q <= 1'b0;
            adl_drive_q    <= 1'b0;
            adh_drive_q    <= 1'b0;
            adl_out_q      <= '0;
            adh_out_q      <= '0;
            busy_q         <= 1'b1;
            vec_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            open_q         <= open_d;
            cnt_q          <= cnt_d;
            vec_lo_q       <= vec_lo_d;
            lo_q           <= lo_d;
            hi_q           <= hi_d;
            irq_q          <= irq_d;
            cmd_ready_q    <= cmd_ready_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            pcl_pcl_q      <= pcl_pcl_d;
            adl_pcl_q      <= adl_pcl_d;
            pch_pch_q      <= pch_pch_d;
            adh_pch_q      <= adh_pch_d;
            increment_pc_q <= increment_pc_d;
            adl_drive_q    <= adl_drive_d;
            adh_drive_q    <= adh_drive_d;
            adl_out_q      <= adl_out_d;
            adh_out_q      <= adh_out_d;
            busy_q         <= busy_d;
            vec_done_q     <= vec_done_d;
        end
    end

    // Next state: a step opens after one phase_2_rising and commits on the following one.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        open_d   = open_q;
        cnt_d    = cnt_q;
        vec_lo_d = vec_lo_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        nmi_clr  = 1'b0;
        case (state_q)
            RST_VEC: begin
                state_d  = VLO_REQ;
                vec_lo_d = VEC_RST_LO;
            end
            IDLE: begin
                if (nmi_pend_q) begin
                    state_d  = VLO_REQ;
                    vec_lo_d = VEC_NMI_LO;
                    nmi_clr  = 1'b1;
                end else if (irq_q) begin
                    state_d  = VLO_REQ;
                    vec_lo_d = VEC_IRQ_LO;
                end else if (cmd_valid) begin
                    if (cmd_op == OP_BRK) begin
                        state_d  = VLO_REQ;
                        vec_lo_d = VEC_IRQ_LO;
                    end else begin
                        state_d = STEP;
                        op_d    = cmd_op;
                        open_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end
            end
            STEP, VLOAD: begin
                if (!open_q) begin
                    if (phase_2_rising) begin
                        open_d = 1'b1;
                        cnt_d  = '0;
                    end
                end else if (phase_2_rising) begin
                    state_d = IDLE;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            VLO_REQ: state_d = VLO_WAIT;
            VLO_WAIT: begin
                if (mem_rvalid) begin
                    lo_d    = mem_rdata;
                    state_d = VHI_REQ;
                end
            end
            VHI_REQ: state_d = VHI_WAIT;
            VHI_WAIT: begin
                if (mem_rvalid) begin
                    hi_d    = mem_rdata;
                    state_d = VLOAD;
                    open_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = RST_VEC;
        endcase
    end

    // Output decode of the next state, so outputs line up with the registered state.
    always_comb begin
        cmd_ready_d    = 1'b0;
        mem_req_d      = 1'b0;
        mem_addr_d     = '0;
        pcl_pcl_d      = 1'b0;
        adl_pcl_d      = 1'b0;
        pch_pch_d      = 1'b0;
        adh_pch_d      = 1'b0;
        increment_pc_d = 1'b0;
        adl_drive_d    = 1'b0;
        adh_drive_d    = 1'b0;
        adl_out_d      = '0;
        adh_out_d      = '0;
        busy_d         = (state_d != IDLE);
        vec_done_d     = (state_q == VLOAD) && open_q && phase_2_rising;
        strb_on        = open_d && (cnt_d < CNT_W'(STROBE_LEN));
        case (state_d)
            IDLE: cmd_ready_d = ~nmi_pend_d & ~irq_d;
            STEP: begin
                increment_pc_d = (op_d == OP_INC);
                if (strb_on) begin
                    if (op_d == OP_LOAD_AB) begin
                        adl_pcl_d = 1'b1;
                        adh_pch_d = 1'b1;
                    end else begin
                        pcl_pcl_d = 1'b1;
                        pch_pch_d = 1'b1;
                    end
                end
            end
            VLO_REQ: begin
                mem_req_d  = 1'b1;
                mem_addr_d = {VEC_HI_BYTE, vec_lo_d};
            end
            VLO_WAIT: mem_addr_d = {VEC_HI_BYTE, vec_lo_d};
            VHI_REQ: begin
                mem_req_d  = 1'b1;
                mem_addr_d = {VEC_HI_BYTE, vec_lo_d | 8'h01};
            end
            VHI_WAIT: mem_addr_d = {VEC_HI_BYTE, vec_lo_d | 8'h01};
            VLOAD: begin
                adl_drive_d = 1'b1;
                adh_drive_d = 1'b1;
                adl_out_d   = lo_d;
                adh_out_d   = hi_d;
                adl_pcl_d   = strb_on;
                adh_pch_d   = strb_on;
            end
            default: ;
        endcase
    end

    assign cmd_ready    = cmd_ready_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign pcl_pcl      = pcl_pcl_q;
    assign adl_pcl      = adl_pcl_q;
    assign pch_pch      = pch_pch_q;
    assign adh_pch      = adh_pch_q;
    assign increment_pc = increment_pc_q;
    assign adl_drive    = adl_drive_q;
    assign adh_drive    = adh_drive_q;
    assign adl_out      = adl_out_q;
    assign adh_out      = adh_out_q;
    assign busy         = busy_q;
    assign vec_done     = vec_done_q;
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter STROBE_LEN, default 2, meaning sys_clock cycles each PC load strobe is held high (legal range 1..7).
REQ-002 Parameter VEC_HI_BYTE, default 8'hFF, meaning the high address byte for every vector fetch.
REQ-003 sys_clock  input  1  system clock; reset  input  1  reset, synchronous, active-high.
REQ-004 phase_2_rising  input  1  one-cycle pulse marking the PC commit point.
REQ-005 cmd_valid  input  1 / cmd_op  input  2 / cmd_ready  output  1  PC step command handshake; op 0=HOLD, 1=INC, 2=LOAD_AB, 3=BRK.
REQ-006 irq_n  input  1  level IRQ, active-low; i_flag  input  1  IRQ mask; nmi_n  input  1  NMI, falling-edge sensitive.
REQ-007 mem_req  output  1 / mem_addr  output  16 / mem_rdata  input  8 / mem_rvalid  input  1  vector byte read port.
REQ-008 pcl_pcl, adl_pcl, pch_pch, adh_pch, increment_pc  output  1 each  PC source select and increment controls.
REQ-009 adl_drive, adh_drive  output  1 each / adl_out, adh_out  output  8 each  address bus drive enables and values.
REQ-010 busy  output  1  sequence in progress; vec_done  output  1  one-cycle pulse when a vector load commits.

Function
REQ-011 States: RST_VEC, IDLE, STEP, VLO_REQ, VLO_WAIT, VHI_REQ, VHI_WAIT, VLOAD.
REQ-012 cmd_ready SHALL be 1 only in IDLE with no pending NMI or unmasked IRQ; a command is accepted on cmd_valid and cmd_ready, which moves to STEP.
REQ-013 A PC step SHALL open on the first cycle following a phase_2_rising pulse.
REQ-014 The step's strobes SHALL be high for STROBE_LEN cycles, then low until the step ends.
REQ-015 The step SHALL end at the next phase_2_rising.
REQ-016 Strobes SHALL never stay high across two commits, so every load shows a fresh rising edge.
REQ-017 Step decoding: HOLD=pcl_pcl+pch_pch, increment_pc 0; INC=pcl_pcl+pch_pch, increment_pc 1.
REQ-018 LOAD_AB SHALL assert adl_pcl+adh_pch with increment_pc 0; the caller drives the address buses.
REQ-019 increment_pc SHALL be held stable for the whole step, including the commit cycle.
REQ-020 Vector select: NMI=FFFA, IRQ/BRK=FFFE, reset=FFFC; the high byte is always VEC_HI_BYTE.
REQ-021 Priority at IDLE: pending NMI > unmasked IRQ (irq_n=0, i_flag=0) > BRK command > other commands.
REQ-022 An NMI falling edge SHALL set a pending flag, cleared when its vector sequence enters VLO_REQ.
REQ-023 Further NMI edges during that sequence SHALL re-arm the flag.
REQ-024 VLO_REQ SHALL pulse mem_req for 1 cycle with mem_addr set to the vector, then move to VLO_WAIT.
REQ-025 VLO_WAIT SHALL capture mem_rdata on mem_rvalid, then move to VHI_REQ with mem_addr set to vector+1.
REQ-026 VHI_REQ and VHI_WAIT SHALL capture the high byte the same way, then move to VLOAD.
REQ-027 mem_rvalid outside the WAIT states SHALL be ignored; wait length is unbounded.
REQ-028 VLOAD SHALL drive adl_out/adh_out with the captured bytes and adl_drive/adh_drive high for the whole step.
REQ-029 VLOAD SHALL assert adl_pcl+adh_pch under the REQ-013..016 timing, with increment_pc 0.
REQ-030 vec_done SHALL pulse on the commit cycle, then the FSM returns to IDLE.
REQ-031 adl_drive and adh_drive SHALL be 0 in all states except VLOAD.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 phase_2_rising arriving while a vector fetch is still waiting SHALL have no effect.

Reset
REQ-034 While reset is high: state RST_VEC, pending NMI cleared, captured bytes 0.
REQ-035 While reset is high, all strobes, drives, mem_req, vec_done and cmd_ready SHALL be 0 and busy SHALL be 1.
REQ-036 The cycle after reset deasserts, the FSM SHALL start the FFFC fetch via VLO_REQ.
REQ-037 Reset asserted mid-sequence SHALL abort it within the same cycle with no further strobes.

Configuration
REQ-038 With macro PC_SEQ_NMI_EN defined, NMI edge detection, the pending flag and the FFFA vector SHALL exist.
REQ-039 Without PC_SEQ_NMI_EN, nmi_n SHALL be ignored and the FFFA vector SHALL never be fetched.

Verification
REQ-040 Reset release, memory returns 34 then 12 -> reads at FFFC, FFFD; VLOAD drives adl 34, adh 12; one vec_done pulse.
REQ-041 INC accepted, STROBE_LEN=2 -> pcl_pcl/pch_pch high exactly 2 cycles after phase_2_rising; increment_pc 1 through the next commit.
REQ-042 irq_n=0 with i_flag=1 plus INC command -> INC runs; set i_flag=0 -> FFFE fetch; cmd_ready 0 meanwhile.
REQ-043 NMI edge and IRQ both pending in IDLE -> FFFA fetched first, then FFFE (PC_SEQ_NMI_EN builds only).
REQ-044 Reset asserted during VHI_WAIT -> all outputs 0 the next cycle; a fresh FFFC sequence runs after release.
REQ-045 Back-to-back INC commands -> every strobe is low for at least 1 cycle before its next rising edge.
